commit_trace: RTL and testbench

Dual-slot commit trace serializer for the dual-issue core. Sits directly downstream of the execute stage's two retire lanes (calc0/calc1) and takes their integer register write-backs. Entries go into a small FIFO in program order and drain through a single valid/ready trace port. A bench monitor or an on-chip trace sink consumes that port. The block takes no part in architectural state: dropped entries only raise `overflow`, and the core is never stalled.

---
 rtl/commit_trace_if.sv | 47 ++++
 rtl/commit_trace.sv | 151 +++++++++++++++
 tb/tb_commit_trace.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_if.sv
// commit_trace_if: bundles the two retire lanes and the trace port of
// commit_trace.
//   master : driven by the core/sink side (commit lanes, trace_ready)
//   slave  : the commit_trace block (drives trace_* outputs)
// The trace_time field exists only when COMMIT_TRACE_TIMESTAMP_EN is defined.
interface commit_trace_if #(
  parameter int TS_WIDTH = 32
);
  logic        commit0_valid;
  logic [31:0] commit0_pc;
  logic [4:0]  commit0_waddr;
  logic [31:0] commit0_wdata;
  logic        commit1_valid;
  logic [31:0] commit1_pc;
  logic [4:0]  commit1_waddr;
  logic [31:0] commit1_wdata;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_waddr;
  logic [31:0] trace_wdata;
  logic        trace_slot;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] trace_time;
`endif

  modport master (
    output commit0_valid, commit0_pc, commit0_waddr, commit0_wdata,
    output commit1_valid, commit1_pc, commit1_waddr, commit1_wdata,
    output trace_ready,
    input  trace_valid, trace_pc, trace_waddr, trace_wdata, trace_slot
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    , input trace_time
`endif
  );

  modport slave (
    input  commit0_valid, commit0_pc, commit0_waddr, commit0_wdata,
    input  commit1_valid, commit1_pc, commit1_waddr, commit1_wdata,
    input  trace_ready,
    output trace_valid, trace_pc, trace_waddr, trace_wdata, trace_slot
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    , output trace_time
`endif
  );
endinterface

// File: rtl/commit_trace.sv
// commit_trace: dual-lane commit trace serializer.
// Collects integer register write-backs from two retire lanes (lane 0 older
// than lane 1) into a DEPTH-entry FIFO in program order and drains them one
// per cycle over a valid/ready trace port. Never stalls the core: entries
// that find no room are dropped and counted.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   clear       synchronous flush (FIFO, overflow, drop_count, timestamp)
//   bus         commit_trace_if.slave: commit lanes in, trace port out
//   overflow    sticky drop indicator
//   drop_count  saturating 16-bit count of dropped entries
//
// Optional feature: define COMMIT_TRACE_TIMESTAMP_EN to add a free-running
// TS_WIDTH timestamp stored with each entry and shown on bus.trace_time.
module commit_trace #(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  commit_trace_if.slave        bus,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      pc_q    [DEPTH];
  logic [4:0]       waddr_q [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [DEPTH-1:0] slot_q;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_ptr1;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;
  logic [16:0]   drop_sum;
  logic [1:0]    n_drop;
  logic          elig0, elig1, push0, push1, drop0, drop1, pop;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q [DEPTH];
  logic [TS_WIDTH-1:0] tnow_q, tnow_d;
`endif

  always_comb begin
    elig0 = bus.commit0_valid && (bus.commit0_waddr != 5'd0);
    elig1 = bus.commit1_valid && (bus.commit1_waddr != 5'd0);
    // Free space is taken before this cycle's pop: a pop gives no credit.
    free  = CW'(DEPTH) - count_q;
    push0 = elig0 && (free != '0);
    // Lane 1 needs a second free slot only if lane 0 took one.
    push1 = elig1 && (free >= (push0 ? CW'(2) : CW'(1)));
    drop0 = elig0 && !push0;
    drop1 = elig1 && !push1;
    pop   = (count_q != '0) && bus.trace_ready;
    wr_ptr1 = push0 ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    n_drop  = {1'b0, drop0} + {1'b0, drop1};
    drop_sum = {1'b0, drop_q} + 17'(n_drop);

    if (clear) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      drop_d     = 16'd0;
    end else begin
      count_d    = count_q + CW'(push0) + CW'(push1) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push0) + PW'(push1);
      overflow_d = overflow_q | (n_drop != 2'd0);
      drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 32'd0;
        waddr_q[i] <= 5'd0;
        wdata_q[i] <= 32'd0;
      end
      slot_q <= '0;
    end else if (!clear) begin
      if (push0) begin
        pc_q[wr_ptr_q]    <= bus.commit0_pc;
        waddr_q[wr_ptr_q] <= bus.commit0_waddr;
        wdata_q[wr_ptr_q] <= bus.commit0_wdata;
        slot_q[wr_ptr_q]  <= 1'b0;
      end
      if (push1) begin
        pc_q[wr_ptr1]    <= bus.commit1_pc;
        waddr_q[wr_ptr1] <= bus.commit1_waddr;
        wdata_q[wr_ptr1] <= bus.commit1_wdata;
        slot_q[wr_ptr1]  <= 1'b1;
      end
    end
  end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign tnow_d = clear ? '0 : tnow_q + TS_WIDTH'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tnow_q <= '0;
      for (int i = 0; i < DEPTH; i++) ts_q[i] <= '0;
    end else begin
      tnow_q <= tnow_d;
      // Both lanes admitted in one cycle share the same stamp.
      if (!clear) begin
        if (push0) ts_q[wr_ptr_q] <= tnow_q;
        if (push1) ts_q[wr_ptr1]  <= tnow_q;
      end
    end
  end

  assign bus.trace_time = ts_q[rd_ptr_q];
`endif

  assign bus.trace_valid = (count_q != '0);
  assign bus.trace_pc    = pc_q[rd_ptr_q];
  assign bus.trace_waddr = waddr_q[rd_ptr_q];
  assign bus.trace_wdata = wdata_q[rd_ptr_q];
  assign bus.trace_slot  = slot_q[rd_ptr_q];
  assign overflow        = overflow_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_commit_trace.sv
module tb_commit_trace;
  localparam int DEPTH = 8;
  localparam int TSW   = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        overflow;
  logic [15:0] drop_count;

  commit_trace_if #(.TS_WIDTH(TSW)) bus ();

  commit_trace #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        slot;
    logic [31:0] ts;
  } ent_t;

  ent_t        mq[$];
  logic        m_ovf;
  int          m_drops;
  logic [31:0] m_ts;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    m_ts    = 32'd0;
  endtask

  // Effect of one clock edge on the reference model.
  task automatic model_step(input logic clr,
                            input logic v0, input logic [31:0] pc0, input logic [4:0] wa0, input logic [31:0] wd0,
                            input logic v1, input logic [31:0] pc1, input logic [4:0] wa1, input logic [31:0] wd1,
                            input logic rdy);
    bit do_pop;
    int free;
    if (clr) begin
      model_reset();
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      free   = DEPTH - mq.size();
      if (v0 && wa0 != 5'd0) begin
        if (free > 0) begin mq.push_back('{pc0, wa0, wd0, 1'b0, m_ts}); free--; end
        else begin m_drops++; m_ovf = 1'b1; end
      end
      if (v1 && wa1 != 5'd0) begin
        if (free > 0) begin mq.push_back('{pc1, wa1, wd1, 1'b1, m_ts}); free--; end
        else begin m_drops++; m_ovf = 1'b1; end
      end
      if (m_drops > 65535) m_drops = 65535;
      if (do_pop) void'(mq.pop_front());
      m_ts = m_ts + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("trace_valid", bus.trace_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("trace_pc",    bus.trace_pc,    mq[0].pc);
      chk("trace_waddr", bus.trace_waddr, mq[0].wa);
      chk("trace_wdata", bus.trace_wdata, mq[0].wd);
      chk("trace_slot",  bus.trace_slot,  mq[0].slot);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      chk("trace_time",  bus.trace_time,  mq[0].ts);
`endif
    end
    chk("overflow",   overflow,   m_ovf);
    chk("drop_count", drop_count, 64'(m_drops));
  endtask

  // Called at a falling edge: check state, drive inputs, advance one cycle.
  task automatic cyc(input logic clr,
                     input logic v0, input logic [31:0] pc0, input logic [4:0] wa0, input logic [31:0] wd0,
                     input logic v1, input logic [31:0] pc1, input logic [4:0] wa1, input logic [31:0] wd1,
                     input logic rdy);
    check_all();
    clear             = clr;
    bus.commit0_valid = v0;  bus.commit0_pc = pc0; bus.commit0_waddr = wa0; bus.commit0_wdata = wd0;
    bus.commit1_valid = v1;  bus.commit1_pc = pc1; bus.commit1_waddr = wa1; bus.commit1_wdata = wd1;
    bus.trace_ready   = rdy;
    model_step(clr, v0, pc0, wa0, wd0, v1, pc1, wa1, wd1, rdy);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0, rdy);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd, input logic rdy);
    cyc(1'b0, 1'b1, pc, wa, wd, 1'b0, 0, 0, 0, rdy);
  endtask

  task automatic push2(input logic [31:0] pc, input logic rdy);
    cyc(1'b0, 1'b1, pc, 5'd1, pc ^ 32'hA5A5, 1'b1, pc + 32'd4, 5'd2, pc ^ 32'h5A5A, rdy);
  endtask

  task automatic rand_cycles(input int n, input int rdy_pct);
    logic clr, v0, v1, rdy;
    logic [4:0] wa0, wa1;
    for (int i = 0; i < n; i++) begin
      clr = ($urandom_range(0, 59) == 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      wa0 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wa1 = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdy = ($urandom_range(0, 99) < rdy_pct);
      cyc(clr, v0, $urandom, wa0, $urandom, v1, $urandom, wa1, $urandom, rdy);
    end
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    bus.commit0_valid = 1'b0; bus.commit0_pc = '0; bus.commit0_waddr = '0; bus.commit0_wdata = '0;
    bus.commit1_valid = 1'b0; bus.commit1_pc = '0; bus.commit1_waddr = '0; bus.commit1_wdata = '0;
    bus.trace_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_valid",    bus.trace_valid, 1'b0);
    chk("rst_pc",       bus.trace_pc,    32'd0);
    chk("rst_waddr",    bus.trace_waddr, 5'd0);
    chk("rst_wdata",    bus.trace_wdata, 32'd0);
    chk("rst_slot",     bus.trace_slot,  1'b0);
    chk("rst_overflow", overflow,        1'b0);
    chk("rst_drops",    drop_count,      16'd0);
    reset = 1'b1;

    // idle after reset
    idle(5, 1'b0);

    // single push
    push1(32'h8000_0000, 5'd5, 32'h1234, 1'b0);
    chk("single_valid", bus.trace_valid, 1'b1);
    chk("single_pc",    bus.trace_pc,    32'h8000_0000);
    chk("single_waddr", bus.trace_waddr, 5'd5);
    chk("single_wdata", bus.trace_wdata, 32'h1234);
    chk("single_slot",  bus.trace_slot,  1'b0);
    idle(1, 1'b1);
    chk("single_drained", bus.trace_valid, 1'b0);

    // dual push ordering
    cyc(1'b0, 1'b1, 32'h100, 5'd7, 32'h11, 1'b1, 32'h104, 5'd8, 32'h22, 1'b1);
    chk("dual_pc0",   bus.trace_pc,   32'h100);
    chk("dual_slot0", bus.trace_slot, 1'b0);
    idle(1, 1'b1);
    chk("dual_pc1",   bus.trace_pc,   32'h104);
    chk("dual_slot1", bus.trace_slot, 1'b1);
    idle(1, 1'b1);
    chk("dual_empty", bus.trace_valid, 1'b0);

    // x0 filter
    cyc(1'b0, 1'b1, 32'h200, 5'd3, 32'h33, 1'b1, 32'h204, 5'd0, 32'h44, 1'b0);
    chk("x0_waddr", bus.trace_waddr, 5'd3);
    idle(1, 1'b1);
    chk("x0_empty", bus.trace_valid, 1'b0);
    chk("x0_drops", drop_count, 16'd0);

    // overflow
    for (int i = 0; i < 7; i++) push1(32'h300 + 32'(4 * i), 5'(i + 1), 32'(i), 1'b0);
    push2(32'h400, 1'b0);
    chk("ovf_set",    overflow,   1'b1);
    chk("ovf_drops1", drop_count, 16'd1);
    push2(32'h500, 1'b0);
    chk("ovf_drops3", drop_count, 16'd3);

    // drain 5, push 5 so the pointers wrap, then drain in order
    idle(5, 1'b1);
    for (int i = 0; i < 5; i++) push1(32'h600 + 32'(4 * i), 5'(i + 9), 32'(i + 100), 1'b0);
    idle(DEPTH + 1, 1'b1);

    // clear with a simultaneous push
    push1(32'h700, 5'd4, 32'h77, 1'b0);
    cyc(1'b1, 1'b1, 32'h704, 5'd6, 32'h78, 1'b0, 0, 0, 0, 1'b0);
    chk("clr_valid", bus.trace_valid, 1'b0);
    chk("clr_drops", drop_count,      16'd0);
    chk("clr_ovf",   overflow,        1'b0);

    // randomized traffic, biased to fill
    rand_cycles(400, 30);

    // asynchronous reset mid-operation
    push2(32'h900, 1'b0);
    #2 reset = 1'b0;
    #1 chk("async_rst_valid", bus.trace_valid, 1'b0);
    chk("async_rst_drops", drop_count, 16'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(10, 1'b0);
    push1(32'hA00, 5'd9, 32'h99, 1'b0);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    chk("ts_cycle10", bus.trace_time, 32'd10);
`endif
    chk("post_rst_pc", bus.trace_pc, 32'hA00);

    // randomized traffic, biased to drain
    rand_cycles(300, 80);
    idle(DEPTH + 1, 1'b1);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
